// File: rtl/poker_pkg.sv
// Shared poker definitions: card encoding, hand/deck sizes, dealer states
// and the LFSR feedback mask used by the card dealer.
package poker_pkg;

    localparam int CARD_W    = 6;
    localparam int HAND_SIZE = 5;
    localparam int DECK_SIZE = 52;

    // Galois feedback mask for x^8+x^6+x^5+x^4+1 (right-shifting form)
    localparam logic [7:0] LFSR_MASK = 8'hB8;

    typedef logic [CARD_W-1:0] card_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        LOAD = 2'd2
    } dealer_state_t;

    // An all-zero LFSR would lock up, so zero seeds become 8'h01
    function automatic logic [7:0] fix_seed(input logic [7:0] s);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

endpackage

// File: rtl/card_dealer_if.sv
// Request/hand bundle between a requester (master) and the card dealer
// (slave). seed_in exists only when CARD_DEALER_SEED_LOAD_EN is defined.
interface card_dealer_if;
    import poker_pkg::*;

    logic       deal_req;
    logic       new_deck;
`ifdef CARD_DEALER_SEED_LOAD_EN
    logic [7:0] seed_in;
`endif
    card_t      card_out [HAND_SIZE];
    logic       enable_all;
    logic       busy;
    logic       deck_empty;
    logic [5:0] cards_left;

    modport master (
        output deal_req, new_deck
`ifdef CARD_DEALER_SEED_LOAD_EN
        , seed_in
`endif
        , input card_out, enable_all, busy, deck_empty, cards_left
    );

    modport slave (
        input deal_req, new_deck
`ifdef CARD_DEALER_SEED_LOAD_EN
        , seed_in
`endif
        , output card_out, enable_all, busy, deck_empty, cards_left
    );

endinterface

// File: rtl/deal_lfsr.sv
// 8-bit Galois LFSR (period 255) for the card dealer. Advances on step,
// loads on load; zero seeds are replaced by 8'h01. Only the low six bits
// are exported since they form the candidate card index.
module deal_lfsr
    import poker_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic       load,
    input  logic [7:0] load_val,
    output card_t      cand
);

    logic [7:0] value;
    logic [7:0] next_value;

    // One Galois shift: drop the LSB and fold it back through the mask
    always_comb begin
        next_value = {1'b0, value[7:1]} ^ (value[0] ? LFSR_MASK : 8'h00);
    end

    // Load has priority over step; the register holds otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= fix_seed(SEED);
        end else if (load) begin
            value <= fix_seed(load_val);
        end else if (step) begin
            value <= next_value;
        end
    end

    assign cand = value[5:0];

endmodule

// File: rtl/card_dealer.sv
// Card dealer: deals five unique cards per hand from a persistent 52-card
// deck using LFSR rejection sampling, then strobes enable_all for one
// cycle so the player bank loads all five slots in parallel.
// Optional feature macro: CARD_DEALER_SEED_LOAD_EN (runtime reshuffle seed).
module card_dealer
    import poker_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic          clk,
    input  logic          reset,
    card_dealer_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_DRAW = DRAW;
    localparam logic [1:0] ST_LOAD = LOAD;

    logic [1:0]           state;
    logic [2:0]           slot;
    logic [DECK_SIZE-1:0] dealt;
    card_t                cand;
    logic [7:0]           load_val;
    logic                 in_idle;
    logic                 reshuffle;
    logic                 start;
    logic                 refuse;
    logic                 accept;

`ifdef CARD_DEALER_SEED_LOAD_EN
    assign load_val = bus.seed_in;
`else
    assign load_val = SEED;
`endif

    // Requests are only honoured in IDLE; reshuffle beats a simultaneous deal
    assign in_idle   = (state == ST_IDLE);
    assign reshuffle = in_idle && bus.new_deck;
    assign start     = in_idle && !bus.new_deck && bus.deal_req
                       && (bus.cards_left >= 6'd5);
    assign refuse    = in_idle && !bus.new_deck && bus.deal_req
                       && (bus.cards_left < 6'd5);

    // Candidate is valid only if it is a real card not already dealt
    assign accept = (state == ST_DRAW) && (cand < card_t'(DECK_SIZE))
                    && !dealt[cand];

    deal_lfsr #(.SEED(SEED)) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .step     (state == ST_DRAW),
        .load     (reshuffle),
        .load_val (load_val),
        .cand     (cand)
    );

    // Dealer FSM: IDLE -> DRAW until five accepts -> LOAD strobe -> IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            slot  <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_DRAW;
                        slot  <= 3'd0;
                    end
                end
                ST_DRAW: begin
                    if (accept) begin
                        slot <= slot + 3'd1;
                        if (slot == 3'(HAND_SIZE - 1)) begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Deck bookkeeping: dealt mask, remaining count and sticky empty flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dealt          <= '0;
            bus.cards_left <= 6'(DECK_SIZE);
            bus.deck_empty <= 1'b0;
        end else if (reshuffle) begin
            dealt          <= '0;
            bus.cards_left <= 6'(DECK_SIZE);
            bus.deck_empty <= 1'b0;
        end else if (refuse) begin
            bus.deck_empty <= 1'b1;
        end else if (accept) begin
            dealt[cand]    <= 1'b1;
            bus.cards_left <= bus.cards_left - 6'd1;
        end
    end

    // Hand slots fill as cards are accepted and hold until overwritten
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < HAND_SIZE; i++) begin
                bus.card_out[i] <= '0;
            end
        end else if (accept) begin
            bus.card_out[slot] <= cand;
        end
    end

    assign bus.enable_all = (state == ST_LOAD);
    assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: a transaction-level deck model
// predicts each hand and its busy window; a per-cycle compare process
// checks the DUT against it, backed by directed scenarios and literals.
module tb_card_dealer;
    import poker_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    card_dealer_if bus ();

    card_dealer #(.SEED(8'hA5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int strobes = 0;

    // Reference model state
    logic [7:0] m_lfsr  = 8'hA5;
    bit   [51:0] m_mask = '0;
    int   m_left  = 52;
    bit   m_empty = 1'b0;
    int   m_cnt   = 0;
    int   m_hand [5] = '{0, 0, 0, 0, 0};

    int exp_first [5] = '{37, 42, 2, 1, 24};
    int bank [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    // Draw a full hand from the model deck; returns the number of draw cycles
    function automatic int model_deal();
        int k = 0;
        int n = 0;
        int c;
        while (k < 5 && n < 5000) begin
            c = int'(m_lfsr[5:0]);
            if (c < 52 && !m_mask[c]) begin
                m_hand[k] = c;
                m_mask[c] = 1'b1;
                k++;
            end
            m_lfsr = lfsr_next(m_lfsr);
            n++;
        end
        m_left -= 5;
        return n;
    endfunction

    // Model update on every clock edge (and immediately on reset)
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_lfsr = 8'hA5; m_mask = '0; m_left = 52; m_empty = 0; m_cnt = 0;
                for (int i = 0; i < 5; i++) m_hand[i] = 0;
            end else if (m_cnt > 0) begin
                m_cnt--;
            end else if (bus.new_deck) begin
`ifdef CARD_DEALER_SEED_LOAD_EN
                m_lfsr = (bus.seed_in == 8'h00) ? 8'h01 : bus.seed_in;
`else
                m_lfsr = 8'hA5;
`endif
                m_mask = '0; m_left = 52; m_empty = 0;
            end else if (bus.deal_req) begin
                if (m_left >= 5) m_cnt = model_deal() + 1;
                else m_empty = 1;
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("busy", int'(bus.busy), int'(m_cnt > 0));
            chk("enable_all", int'(bus.enable_all), int'(m_cnt == 1));
            chk("deck_empty", int'(bus.deck_empty), int'(m_empty));
            if (m_cnt <= 1) begin
                chk("cards_left", int'(bus.cards_left), m_left);
                for (int i = 0; i < 5; i++) chk("card_out", int'(bus.card_out[i]), m_hand[i]);
            end
            if (bus.enable_all) strobes++;
        end
    end

    // Bank-style capture on the load strobe
    always @(posedge clk) begin
        if (bus.enable_all) begin
            for (int i = 0; i < 5; i++) bank[i] <= int'(bus.card_out[i]);
        end
    end

    task automatic pulse(input bit d, input bit n);
        @(negedge clk);
        bus.deal_req = d; bus.new_deck = n;
        @(negedge clk);
        bus.deal_req = 0; bus.new_deck = 0;
    endtask

    task automatic wait_strobe();
        for (int i = 0; i < 3000; i++) begin
            if (bus.enable_all) return;
            @(negedge clk);
        end
        chk("strobe_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            if (!bus.busy) return;
            @(negedge clk);
        end
        chk("idle_timeout", 0, 1);
    endtask

    task automatic chk_first_hand(input string name);
        for (int i = 0; i < 5; i++) chk(name, int'(bus.card_out[i]), exp_first[i]);
    endtask

    bit seen [52];
    int nuniq;
    int s0;
    int left0;

    initial begin
        bus.deal_req = 0;
        bus.new_deck = 0;
`ifdef CARD_DEALER_SEED_LOAD_EN
        bus.seed_in = 8'h00;
`endif
        repeat (3) @(negedge clk);
        reset = 0;

        // Reset state and model pins
        chk("rst_cards_left", int'(bus.cards_left), 52);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_enable_all", int'(bus.enable_all), 0);
        chk("rst_deck_empty", int'(bus.deck_empty), 0);
        chk("rst_card0", int'(bus.card_out[0]), 0);
        chk("model_lfsr_step", int'(lfsr_next(8'hA5)), 8'hEA);

        // First hand from SEED=A5
        for (int i = 0; i < 52; i++) seen[i] = 0;
        nuniq = 0;
        s0 = strobes;
        for (int h = 0; h < 10; h++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pulse(1, 0);
            wait_strobe();
            if (h == 0) begin
                chk_first_hand("first_hand");
                for (int i = 0; i < 5; i++) chk("model_first_hand", m_hand[i], exp_first[i]);
            end
            for (int i = 0; i < 5; i++) begin
                int c;
                c = int'(bus.card_out[i]);
                chk("card_range", int'(c < 52), 1);
                if (c < 52 && !seen[c]) begin
                    seen[c] = 1;
                    nuniq++;
                end
            end
            wait_idle();
            if (h == 0) chk("left_after_one", int'(bus.cards_left), 47);
        end
        chk("distinct_50", nuniq, 50);
        chk("left_after_ten", int'(bus.cards_left), 2);
        @(negedge clk);
        chk("ten_strobes", strobes - s0, 10);

        // Eleventh request is refused
        s0 = strobes;
        pulse(1, 0);
        repeat (4) @(negedge clk);
        chk("refuse_empty", int'(bus.deck_empty), 1);
        chk("refuse_left", int'(bus.cards_left), 2);
        chk("refuse_no_strobe", strobes - s0, 0);

        // new_deck wins over a simultaneous deal_req
        pulse(1, 1);
        repeat (2) @(negedge clk);
        chk("reshuffle_left", int'(bus.cards_left), 52);
        chk("reshuffle_empty", int'(bus.deck_empty), 0);
        chk("reshuffle_no_deal", strobes - s0, 0);
        pulse(1, 0);
        wait_strobe();
        chk_first_hand("hand_after_reshuffle");
        wait_idle();

        // Reset on the third DRAW cycle aborts the deal
        s0 = strobes;
        pulse(1, 0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_enable", int'(bus.enable_all), 0);
        chk("abort_left", int'(bus.cards_left), 52);
        for (int i = 0; i < 5; i++) chk("abort_card", int'(bus.card_out[i]), 0);
        @(negedge clk);
        reset = 0;
        chk("abort_no_strobe", strobes - s0, 0);
        pulse(1, 0);
        wait_strobe();
        chk_first_hand("hand_after_abort");
        wait_idle();

        // Requests while busy are ignored
        s0 = strobes;
        left0 = int'(bus.cards_left);
        pulse(1, 0);
        bus.deal_req = 1; bus.new_deck = 1;
        @(negedge clk);
        @(negedge clk);
        bus.deal_req = 0; bus.new_deck = 0;
        wait_strobe();
        wait_idle();
        repeat (3) @(negedge clk);
        chk("busy_ignore_strobes", strobes - s0, 1);
        chk("busy_ignore_left", int'(bus.cards_left), left0 - 5);

        // Random traffic checked by the model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.deal_req = ($urandom_range(0, 3) == 0);
            bus.new_deck = ($urandom_range(0, 24) == 0);
        end
        bus.deal_req = 0; bus.new_deck = 0;
        wait_idle();

`ifdef CARD_DEALER_SEED_LOAD_EN
        // Runtime seed of zero maps to 8'h01; bank captures the same hand
        bus.seed_in = 8'h00;
        pulse(0, 1);
        pulse(1, 0);
        wait_strobe();
        @(negedge clk);
        for (int i = 0; i < 5; i++) chk("bank_capture", bank[i], m_hand[i]);
        wait_idle();
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
